// File: rtl/spdif_ctrl.sv
// spdif_ctrl: 4-deep sample FIFO, bit-rate divider and sample feed for an SPDIF core.
// SPDIF_CTRL_REPEAT_EN defined: an underrun repeats the last sample instead of sending zero.
module spdif_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        mute_i,
    input  logic [15:0] div_i,
    input  logic        inport_valid_i,
    input  logic [31:0] inport_data_i,
    output logic        inport_accept_o,
    output logic        bit_out_en_o,
    output logic [31:0] sample_o,
    input  logic        sample_req_i,
    output logic        underrun_o,
    input  logic        clear_i,
    output logic [2:0]  level_o,
    output logic        running_o
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    state_t      state, state_next;
    logic [31:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [15:0] count;
    logic        push, pop, empty, enter_run, stay_run, req_ok, req_under, wrap;
    logic [31:0] under_val;
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (!enable_i) state_next = IDLE;
        else if (state == IDLE) state_next = PRIME;
        else if (state == PRIME && level_o >= 3'd2) state_next = RUN;
    end
    always_comb begin
        running_o       = state == RUN;
        inport_accept_o = level_o != 3'd4 && state != IDLE;
    end
    always_comb begin
        empty     = level_o == 3'd0;
        enter_run = state == PRIME && state_next == RUN;
        stay_run  = state == RUN && state_next == RUN;
        req_ok    = stay_run && sample_req_i && !empty;
        req_under = stay_run && sample_req_i && empty;
        push      = inport_valid_i && inport_accept_o;
        pop       = enter_run || req_ok;
        wrap      = count >= div_i;
`ifdef SPDIF_CTRL_REPEAT_EN
        under_val = mute_i ? 32'd0 : sample_o;
`else
        under_val = 32'd0;
`endif
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= inport_data_i;
    end
    // Underrun survives the flush on entering IDLE; only reset or clear_i drops it.
    always_ff @(posedge clk_i) begin
        if (rst_i) underrun_o <= 1'b0;
        else if (req_under) underrun_o <= 1'b1;
        else if (clear_i) underrun_o <= 1'b0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || state_next == IDLE) begin
            level_o      <= 3'd0;
            wr_ptr       <= 2'd0;
            rd_ptr       <= 2'd0;
            count        <= 16'd0;
            bit_out_en_o <= 1'b0;
            sample_o     <= 32'd0;
        end else begin
            level_o      <= level_o + 3'(push) - 3'(pop);
            wr_ptr       <= wr_ptr + 2'(push);
            rd_ptr       <= rd_ptr + 2'(pop);
            bit_out_en_o <= stay_run && wrap;
            count        <= (!stay_run || wrap) ? 16'd0 : count + 16'd1;
            if (pop) sample_o <= mute_i ? 32'd0 : mem[rd_ptr];
            else if (req_under) sample_o <= under_val;
        end
    end
endmodule

// File: tb/tb_spdif_ctrl.sv
// tb_spdif_ctrl: directed scoreboard bench for spdif_ctrl; sample_o updates are checked by a monitor.
module tb_spdif_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        mute_i = 1'b0;
    logic [15:0] div_i = 16'd3;
    logic        inport_valid_i = 1'b0;
    logic [31:0] inport_data_i = 32'd0;
    logic        inport_accept_o;
    logic        bit_out_en_o;
    logic [31:0] sample_o;
    logic        sample_req_i = 1'b0;
    logic        underrun_o;
    logic        clear_i = 1'b0;
    logic [2:0]  level_o;
    logic        running_o;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    spdif_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .mute_i(mute_i), .div_i(div_i),
        .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i),
        .inport_accept_o(inport_accept_o), .bit_out_en_o(bit_out_en_o), .sample_o(sample_o),
        .sample_req_i(sample_req_i), .underrun_o(underrun_o), .clear_i(clear_i),
        .level_o(level_o), .running_o(running_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask
    task automatic push_word(input logic [31:0] d);
        inport_valid_i = 1'b1;
        inport_data_i  = d;
        tick();
        inport_valid_i = 1'b0;
    endtask
    task automatic req(input logic [31:0] exp);
        exp_q.push_back(exp);
        sample_req_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
        tick();
    endtask
    // Monitor: sample_o is new after RUN entry or one edge after an accepted request.
    logic run_prev = 1'b0;
    logic req_cap = 1'b0;
    always @(negedge clk_i) begin
        if ((running_o && !run_prev) || req_cap) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample_unexpected: got 0x%08h with empty queue", sample_o);
            end else check("sample_o", sample_o, exp_q.pop_front());
        end
        run_prev = running_o;
        req_cap  = sample_req_i && running_o && enable_i && !rst_i;
    end
    localparam logic [31:0] A = 32'h1111_2222, B = 32'h3333_4444, C = 32'h5555_6666,
        D = 32'h7777_8888, E = 32'h9999_aaaa, F = 32'hbbbb_cccc, M = 32'hdead_beef, N = 32'hcafe_f00d;
`ifdef SPDIF_CTRL_REPEAT_EN
    localparam logic [31:0] UNDER_F = F, UNDER_N = N;
`else
    localparam logic [31:0] UNDER_F = 32'd0, UNDER_N = 32'd0;
`endif
    initial begin
        tick();
        tick();
        check("rst_level", 32'(level_o), 0);
        check("rst_accept", 32'(inport_accept_o), 0);
        check("rst_running", 32'(running_o), 0);
        check("rst_sample", sample_o, 0);
        check("rst_underrun", 32'(underrun_o), 0);
        check("rst_strobe", 32'(bit_out_en_o), 0);
        rst_i = 1'b0;
        enable_i = 1'b1;
        tick();
        check("prime_accept", 32'(inport_accept_o), 1);
        push_word(A);
        exp_q.push_back(A);
        push_word(B);
        check("prime_running", 32'(running_o), 0);
        check("prime_level", 32'(level_o), 2);
        tick();
        check("run_entry", 32'(running_o), 1);
        check("run_level", 32'(level_o), 1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("strobe_div3", 32'(bit_out_en_o), 32'(i % 4 == 0));
        end
        inport_valid_i = 1'b1;
        inport_data_i = C; tick();
        inport_data_i = D; tick();
        inport_data_i = E; tick();
        inport_data_i = F;
        check("full_accept", 32'(inport_accept_o), 0);
        check("full_level", 32'(level_o), 4);
        tick();
        check("full_hold", 32'(level_o), 4);
        exp_q.push_back(B);
        sample_req_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
        check("pop_frees_one", 32'(level_o), 3);
        tick();
        inport_valid_i = 1'b0;
        check("refill", 32'(level_o), 4);
        req(C); req(D); req(E); req(F);
        check("drained", 32'(level_o), 0);
        check("no_underrun_yet", 32'(underrun_o), 0);
        req(UNDER_F);
        check("underrun_set", 32'(underrun_o), 1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        check("underrun_clear", 32'(underrun_o), 0);
        exp_q.push_back(UNDER_F);
        sample_req_i = 1'b1;
        clear_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
        clear_i = 1'b0;
        check("set_beats_clear", 32'(underrun_o), 1);
        tick();
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        push_word(32'h0101_0202);
        push_word(32'h0303_0404);
        push_word(32'h0505_0606);
        check("mute_level3", 32'(level_o), 3);
        mute_i = 1'b1;
        req(0); req(0); req(0);
        mute_i = 1'b0;
        check("mute_level0", 32'(level_o), 0);
        check("mute_no_underrun", 32'(underrun_o), 0);
        push_word(32'h1);
        push_word(32'h2);
        push_word(32'h3);
        check("dis_level3", 32'(level_o), 3);
        enable_i = 1'b0;
        tick();
        check("dis_running", 32'(running_o), 0);
        check("dis_level", 32'(level_o), 0);
        check("dis_accept", 32'(inport_accept_o), 0);
        check("dis_sample", sample_o, 0);
        for (int i = 0; i < 6; i++) begin
            check("dis_strobe", 32'(bit_out_en_o), 0);
            tick();
        end
        div_i = 16'd0;
        enable_i = 1'b1;
        tick();
        exp_q.push_back(M);
        push_word(M);
        push_word(N);
        tick();
        check("rerun", 32'(running_o), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("strobe_div0", 32'(bit_out_en_o), 1);
        end
        req(N);
        req(UNDER_N);
        check("underrun_again", 32'(underrun_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        enable_i = 1'b0;
        check("mid_rst_level", 32'(level_o), 0);
        check("mid_rst_accept", 32'(inport_accept_o), 0);
        check("mid_rst_running", 32'(running_o), 0);
        check("mid_rst_sample", sample_o, 0);
        check("mid_rst_underrun", 32'(underrun_o), 0);
        check("mid_rst_strobe", 32'(bit_out_en_o), 0);
        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spdif_ctrl.md
SPDIF_CTRL -- requirements
Module: spdif_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 enable_i  input  1  level; high = run transmitter, low = stop and flush.
REQ-005 mute_i  input  1  level; high = feed zero samples while still consuming FIFO entries.
REQ-006 div_i  input  16  bit-rate divisor; bit_out_en_o period = div_i+1 clocks.
REQ-007 inport_valid_i  input  1  upstream sample valid.
REQ-008 inport_data_i  input  32  upstream sample, [31:16]=right, [15:0]=left.
REQ-009 inport_accept_o  output  1  upstream accept; transfer occurs when valid and accept are both high.
REQ-010 bit_out_en_o  output  1  single-cycle bit-rate strobe to the SPDIF core.
REQ-011 sample_o  output  32  registered next stereo sample presented to the SPDIF core.
REQ-012 sample_req_i  input  1  single-cycle pulse from the SPDIF core; the core has consumed sample_o.
REQ-013 underrun_o  output  1  sticky flag; a sample request found the FIFO empty.
REQ-014 clear_i  input  1  pulse; clears underrun_o.
REQ-015 level_o  output  3  FIFO occupancy, 0..4.
REQ-016 running_o  output  1  high only in state RUN.

Function
REQ-017 The FIFO SHALL be 4 x 32; inport_accept_o = !full && state != IDLE, taken from registered occupancy.
REQ-018 A push SHALL occur on inport_valid_i && inport_accept_o, and a pop on sample_req_i && !empty; a simultaneous push and pop SHALL leave level_o unchanged.
REQ-019 States: IDLE, PRIME, RUN; IDLE->PRIME when enable_i=1; PRIME->RUN when level_o>=2; RUN or PRIME->IDLE when enable_i=0, which takes priority over all other transitions.
REQ-020 Entering IDLE SHALL flush the FIFO (level_o=0), zero the divider counter and zero sample_o; underrun_o SHALL be retained.
REQ-021 Divider: counter increments each clock only in RUN; when count==div_i, bit_out_en_o=1 for that cycle and count<=0; div_i=0 SHALL give a strobe every RUN cycle.
REQ-022 The first bit_out_en_o SHALL occur div_i+1 clocks after entering RUN.
REQ-023 A change of div_i SHALL take effect at the next compare; if count>div_i, the strobe SHALL fire and the counter SHALL wrap on the next cycle.
REQ-024 On entering RUN, sample_o SHALL be loaded with the FIFO head, popping that entry, in the same cycle as the PRIME->RUN transition.
REQ-025 On sample_req_i in RUN with FIFO non-empty: sample_o<=head (or 0 if mute_i), pop; one-cycle latency from sample_req_i to the new sample_o.
REQ-026 On sample_req_i with FIFO empty: underrun_o<=1 and sample_o follows REQ-032; a push in the same cycle SHALL be stored but not used.
REQ-027 sample_req_i SHALL be ignored outside RUN.
REQ-028 If clear_i and an underrun set occur in the same cycle, set SHALL win.
REQ-029 In PRIME, no bit_out_en_o strobes SHALL occur and pushes SHALL be accepted.

Reset
REQ-030 Reset SHALL force: state=IDLE, FIFO empty, level_o=0, counter=0, bit_out_en_o=0, sample_o=0, underrun_o=0, running_o=0, inport_accept_o=0.
REQ-031 Reset asserted mid-operation SHALL reach the REQ-030 state at the next clock edge, overriding every other input.

Configuration
REQ-032 Macro SPDIF_CTRL_REPEAT_EN: defined -> on underrun, sample_o holds its previous value (last sample repeated); undefined -> on underrun, sample_o<=0; mute_i overrides both and forces 0.

Verification
REQ-033 Reset, enable_i=1, div_i=3, push 0x11112222 and 0x33334444 -> RUN one clock after level reaches 2, sample_o=0x11112222, strobes every 4 clocks starting 4 clocks after RUN entry.
REQ-034 Keep inport_valid_i high with sample_req_i idle -> level_o saturates at 4, accept=0, no data loss; a pop then frees exactly one slot.
REQ-035 Drain the FIFO, then pulse sample_req_i -> underrun_o=1, sample_o=0 (macro off) or unchanged (macro on); clear_i -> underrun_o=0; clear_i together with an underrun -> stays 1.
REQ-036 mute_i=1 with 3 entries and 3 requests -> sample_o=0 each time, level_o ends at 0, no underrun.
REQ-037 Deassert enable_i in RUN with level 3 -> next cycle IDLE, level_o=0, no strobes, accept=0; rst_i mid-RUN -> all outputs at reset values.
